// File: rtl/yl3_dec_formatter.sv
// Binary-to-ASCII decimal formatter for the YL-3 eight-digit display driver.
// Sequential double-dabble conversion, leading-zero blanking and overflow pattern, then a load/ready handoff.
module yl3_dec_formatter #(
  parameter int WIDTH    = 27,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      disp_data,
  output logic             disp_load,
  input  logic             disp_ready
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV     = 3'd1,
    FMT      = 3'd2,
    WAIT_RDY = 3'd3,
    LOAD     = 3'd4
  } state_t;

  localparam logic [26:0] MAX_DEC  = 27'd99_999_999;
  localparam logic [63:0] ALL_SP   = 64'h2020_2020_2020_2020;
  localparam logic [63:0] OFLO_PAT = 64'h2020_2020_4F46_4C4F;
  localparam logic [4:0]  LAST     = 5'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] bin;
  logic [31:0]      bcd;
  logic [4:0]       cnt;

  logic [26:0]      in_ext;
  logic             oflo;
  logic [31:0]      bcd_adj;
  logic [63:0]      fmt;
  logic             leading;

  // For WIDTH <= 26 the zero-extended value can never exceed the limit, so this folds to 0.
  assign in_ext = 27'(in_value);
  assign oflo   = (in_ext > MAX_DEC);

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 8; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  // Walk from the most significant nibble; blanking stops at the first nonzero digit or the last digit.
  always_comb begin
    fmt     = '0;
    leading = BLANK_LZ;
    for (int i = 7; i >= 0; i--) begin
      if (i != 0 && leading && bcd[4*i +: 4] == 4'd0) begin
        fmt[8*i +: 8] = 8'h20;
      end else begin
        fmt[8*i +: 8] = {4'h3, bcd[4*i +: 4]};
        leading       = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      disp_data <= ALL_SP;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (oflo) begin
              disp_data <= OFLO_PAT;
              state     <= WAIT_RDY;
            end else begin
              bin   <= in_value;
              bcd   <= '0;
              cnt   <= '0;
              state <= CONV;
            end
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj[30:0], bin, 1'b0};
          cnt        <= cnt + 5'd1;
          if (cnt == LAST) state <= FMT;
        end
        FMT: begin
          disp_data <= fmt;
          state     <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (disp_ready) state <= LOAD;
        end
        LOAD: begin
          // The driver drops ready once it has captured the data.
          if (!disp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign disp_load = (state == LOAD);

endmodule

// File: tb/tb_yl3_dec_formatter.sv
// Directed bench for yl3_dec_formatter: vector table through blanking and non-blanking instances,
// plus hand sequences for driver stall, busy-time input changes and mid-operation resets.
module tb_yl3_dec_formatter;

  localparam int          WIDTH  = 27;
  localparam logic [63:0] ALL_SP = 64'h2020_2020_2020_2020;
  localparam logic [63:0] OFLO   = 64'h2020_2020_4F46_4C4F;

  typedef struct {
    logic [WIDTH-1:0] value;
    logic [63:0]      exp_b;
    logic [63:0]      exp_z;
    int               lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_value = '0;
  logic             in_valid = 1'b0;
  logic             disp_ready = 1'b1;

  logic             in_ready_b, disp_load_b, in_ready_z, disp_load_z;
  logic [63:0]      data_b, data_z;

  int passed = 0;
  int total  = 0;

  vec_t vecs[8];

  always #10 clk = ~clk;

  yl3_dec_formatter #(.WIDTH(WIDTH), .BLANK_LZ(1'b1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .in_value   (in_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready_b),
    .disp_data  (data_b),
    .disp_load  (disp_load_b),
    .disp_ready (disp_ready)
  );

  yl3_dec_formatter #(.WIDTH(WIDTH), .BLANK_LZ(1'b0)) dut_z (
    .clk        (clk),
    .rst        (rst),
    .in_value   (in_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready_z),
    .disp_data  (data_z),
    .disp_load  (disp_load_z),
    .disp_ready (disp_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Presents a value for one cycle; returns #1 after the accept edge.
  task automatic present(input logic [WIDTH-1:0] v);
    @(negedge clk);
    in_value = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edge count from the start of the accept cycle: the accept edge is 1, so a normal
  // conversion raises disp_load at edge WIDTH+3 and the overflow path at edge 2.
  task automatic wait_load(output int n);
    n = 1;
    while (!disp_load_b && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Driver model: sees load one edge after it rises, drops ready, stays busy a few cycles.
  task automatic handshake(input string name);
    @(posedge clk);
    #1;
    check({name, " load second cycle"}, 64'(disp_load_b), 64'd1);
    disp_ready = 1'b0;
    @(posedge clk);
    #1;
    check({name, " load/in_ready after accept"}, 64'({disp_load_b, in_ready_b}), 64'b01);
    repeat (3) @(posedge clk);
    #1;
    disp_ready = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    present(v.value);
    check({name, " in_ready busy"}, 64'(in_ready_b), 64'd0);
    wait_load(n);
    check({name, " latency"}, 64'(n), 64'(v.lat));
    check({name, " data blank"}, data_b, v.exp_b);
    check({name, " data zeros"}, data_z, v.exp_z);
    check({name, " load both"}, 64'(disp_load_z), 64'd1);
    handshake(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;

    vecs[0] = '{27'd12345,       64'h2020_2031_3233_3435, 64'h3030_3031_3233_3435, WIDTH + 3};
    vecs[1] = '{27'd0,           64'h2020_2020_2020_2030, 64'h3030_3030_3030_3030, WIDTH + 3};
    vecs[2] = '{27'd99_999_999,  64'h3939_3939_3939_3939, 64'h3939_3939_3939_3939, WIDTH + 3};
    vecs[3] = '{27'd100_000_000, OFLO,                    OFLO,                    2};
    vecs[4] = '{27'd10_000_000,  64'h3130_3030_3030_3030, 64'h3130_3030_3030_3030, WIDTH + 3};
    vecs[5] = '{27'h7FF_FFFF,    OFLO,                    OFLO,                    2};
    vecs[6] = '{27'd90807,       64'h2020_2039_3038_3037, 64'h3030_3039_3038_3037, WIDTH + 3};
    vecs[7] = '{27'd1,           64'h2020_2020_2020_2031, 64'h3030_3030_3030_3031, WIDTH + 3};

    #2 rst = 1'b1;
    #1;
    check("reset data", data_b, ALL_SP);
    check("reset load", 64'(disp_load_b), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset in_ready", 64'(in_ready_b), 64'd1);
    check("post-reset data", data_z, ALL_SP);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Driver busy for 500 cycles after the result is formatted.
    disp_ready = 1'b0;
    present(27'd7);
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (disp_load_b || in_ready_b || data_b !== 64'h2020_2020_2020_2037) bad++;
      @(posedge clk);
      #1;
    end
    check("stall hold cycles bad", 64'(bad), 64'd0);
    disp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall load on ready", 64'(disp_load_b), 64'd1);
    handshake("stall");

    // in_valid held with a changing value while busy.
    @(negedge clk);
    in_value = 27'd4321;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    bad = 0;
    n = 1;
    while (!disp_load_b && n < 2000) begin
      in_value = WIDTH'($urandom_range(0, 99_999_999));
      if (in_ready_b) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("busy in_ready bad", 64'(bad), 64'd0);
    check("busy latency", 64'(n), 64'(WIDTH + 3));
    check("busy data", data_b, 64'h2020_2020_3433_3231);
    handshake("busy");

    // Reset in the middle of a conversion.
    present(27'd555);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst conv load", 64'(disp_load_b), 64'd0);
    check("rst conv data", data_b, ALL_SP);
    check("rst conv in_ready", 64'(in_ready_b), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0], "after rst conv");

    // Reset while load is asserted.
    present(27'd99);
    wait_load(n);
    check("pre-rst load", 64'(disp_load_b), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst load load", 64'(disp_load_b), 64'd0);
    check("rst load data", data_b, ALL_SP);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[6], "after rst load");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
